pixel_scheduler: RTL and testbench

Frame-level controller that sequences the ray generator. On a start pulse it raster-scans the screen and emits one (screen_x, screen_y) pair per cycle in Q11.21 fixed point with a one-cycle valid strobe. It drives the ray generator's `valid_in`, which has no stall input, so flow control is credit-based: an in-flight counter, replenished by completion pulses from the downstream ray marcher, bounds the pixels outstanding in the generator/marcher pipeline. It reports busy, frame completion and credit-protocol errors to the top-level control.

---
 rtl/common_defs.sv | 19 +
 rtl/raster_counter.sv | 58 +++++
 rtl/pixel_scheduler.sv | 206 ++++++++++++++++++++
 tb/tb_pixel_scheduler.sv | 354 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/common_defs.sv
// Shared scheduler types: FSM state encoding, Q11.21 coordinate type and
// counter-width helper used by pixel_scheduler and raster_counter.
package common_defs;

    typedef logic [31:0] fp;

    localparam int unsigned COORD_FRAC_BITS = 21;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        DRAIN
    } sched_state_t;

    function automatic int unsigned cnt_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/raster_counter.sv
// Column/row raster counters for one frame; clear has priority over advance.
// line_wrap flags the last column, frame_last flags the last pixel of the frame.
module raster_counter
    import common_defs::*;
#(
    parameter int unsigned WIDTH  = 640,
    parameter int unsigned HEIGHT = 480,
    parameter int unsigned COL_W  = cnt_width(WIDTH),
    parameter int unsigned ROW_W  = cnt_width(HEIGHT)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             advance,
    output logic [COL_W-1:0] col,
    output logic [ROW_W-1:0] row,
    output logic             line_wrap,
    output logic             frame_last
);

    localparam logic [COL_W-1:0] COL_LAST = COL_W'(WIDTH - 1);
    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(HEIGHT - 1);

    logic [COL_W-1:0] col_q, col_d;
    logic [ROW_W-1:0] row_q, row_d;

    always_comb begin
        col_d = col_q;
        row_d = row_q;
        if (clear) begin
            col_d = '0;
            row_d = '0;
        end else if (advance) begin
            if (col_q == COL_LAST) begin
                col_d = '0;
                row_d = (row_q == ROW_LAST) ? '0 : row_q + ROW_W'(1);
            end else begin
                col_d = col_q + COL_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            col_q <= '0;
            row_q <= '0;
        end else begin
            col_q <= col_d;
            row_q <= row_d;
        end
    end

    assign col        = col_q;
    assign row        = row_q;
    assign line_wrap  = (col_q == COL_LAST);
    assign frame_last = (col_q == COL_LAST) && (row_q == ROW_LAST);

endmodule

// File: rtl/pixel_scheduler.sv
// Frame raster scheduler with credit-based flow control toward the ray generator.
// Optional PIXEL_SCHED_PERF_EN adds frame_cycles/stall_cycles performance counters.
module pixel_scheduler
    import common_defs::*;
#(
    parameter int unsigned SCREEN_WIDTH  = 640,
    parameter int unsigned SCREEN_HEIGHT = 480,
    parameter int unsigned MAX_INFLIGHT  = 16
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               start,
    input  logic                               abort,
    input  logic                               credit_return,
    output fp                                  screen_x,
    output fp                                  screen_y,
    output logic                               coords_valid,
    output logic                               pixel_last,
    output logic                               busy,
    output logic                               frame_done,
    output logic [$clog2(MAX_INFLIGHT+1)-1:0]  inflight,
    output logic                               credit_err
`ifdef PIXEL_SCHED_PERF_EN
    ,
    output logic [31:0]                        frame_cycles,
    output logic [31:0]                        stall_cycles
`endif
);

    localparam int unsigned COL_W = cnt_width(SCREEN_WIDTH);
    localparam int unsigned ROW_W = cnt_width(SCREEN_HEIGHT);
    localparam int unsigned IW    = $clog2(MAX_INFLIGHT + 1);
    localparam logic [IW-1:0] INFLIGHT_MAX = IW'(MAX_INFLIGHT);

    sched_state_t    state_q, state_d;
    logic [IW-1:0]   inflight_q, inflight_d;
    logic            aborted_q, aborted_d;
    logic            credit_err_q, credit_err_d;
    fp               screen_x_q, screen_x_d;
    fp               screen_y_q, screen_y_d;
    logic            coords_valid_q, coords_valid_d;
    logic            pixel_last_q, pixel_last_d;
    logic            busy_q, busy_d;
    logic            frame_done_q, frame_done_d;

    logic             issue;
    logic             cnt_clear;
    logic [COL_W-1:0] col;
    logic [ROW_W-1:0] row;
    logic             line_wrap;
    logic             frame_last;
    logic             last_pixel;

    raster_counter #(
        .WIDTH  (SCREEN_WIDTH),
        .HEIGHT (SCREEN_HEIGHT),
        .COL_W  (COL_W),
        .ROW_W  (ROW_W)
    ) u_raster (
        .clk        (clk),
        .rst        (rst),
        .clear      (cnt_clear),
        .advance    (issue),
        .col        (col),
        .row        (row),
        .line_wrap  (line_wrap),
        .frame_last (frame_last)
    );

    assign last_pixel = line_wrap & frame_last;

    always_comb begin
        state_d        = state_q;
        aborted_d      = aborted_q;
        credit_err_d   = credit_err_q;
        screen_x_d     = screen_x_q;
        screen_y_d     = screen_y_q;
        coords_valid_d = 1'b0;
        pixel_last_d   = 1'b0;
        frame_done_d   = 1'b0;
        issue          = 1'b0;
        cnt_clear      = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d      = ISSUE;
                    cnt_clear    = 1'b1;
                    credit_err_d = 1'b0;
                    aborted_d    = 1'b0;
                end
            end
            ISSUE: begin
                // Credit check uses the registered count only: a credit in this
                // cycle cannot unblock issue at the limit.
                if (abort) begin
                    aborted_d = 1'b1;
                    state_d   = DRAIN;
                end else if (inflight_q < INFLIGHT_MAX) begin
                    issue          = 1'b1;
                    coords_valid_d = 1'b1;
                    screen_x_d     = fp'(col) << COORD_FRAC_BITS;
                    screen_y_d     = fp'(row) << COORD_FRAC_BITS;
                    pixel_last_d   = last_pixel;
                    if (last_pixel) begin
                        state_d = DRAIN;
                    end
                end
            end
            DRAIN: begin
                if (abort) begin
                    aborted_d = 1'b1;
                end
                if (inflight_q == '0) begin
                    frame_done_d = ~aborted_d;
                    state_d      = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // A spurious credit flags the error even in the cycle start clears it.
        if (credit_return && (inflight_q == '0)) begin
            credit_err_d = 1'b1;
        end

        inflight_d = inflight_q;
        if (issue && !credit_return) begin
            inflight_d = inflight_q + IW'(1);
        end else if (!issue && credit_return && (inflight_q != '0)) begin
            inflight_d = inflight_q - IW'(1);
        end

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q        <= IDLE;
            inflight_q     <= '0;
            aborted_q      <= 1'b0;
            credit_err_q   <= 1'b0;
            screen_x_q     <= '0;
            screen_y_q     <= '0;
            coords_valid_q <= 1'b0;
            pixel_last_q   <= 1'b0;
            busy_q         <= 1'b0;
            frame_done_q   <= 1'b0;
        end else begin
            state_q        <= state_d;
            inflight_q     <= inflight_d;
            aborted_q      <= aborted_d;
            credit_err_q   <= credit_err_d;
            screen_x_q     <= screen_x_d;
            screen_y_q     <= screen_y_d;
            coords_valid_q <= coords_valid_d;
            pixel_last_q   <= pixel_last_d;
            busy_q         <= busy_d;
            frame_done_q   <= frame_done_d;
        end
    end

    assign screen_x     = screen_x_q;
    assign screen_y     = screen_y_q;
    assign coords_valid = coords_valid_q;
    assign pixel_last   = pixel_last_q;
    assign busy         = busy_q;
    assign frame_done   = frame_done_q;
    assign inflight     = inflight_q;
    assign credit_err   = credit_err_q;

`ifdef PIXEL_SCHED_PERF_EN
    logic [31:0] frame_cycles_q, frame_cycles_d;
    logic [31:0] stall_cycles_q, stall_cycles_d;

    always_comb begin
        frame_cycles_d = frame_cycles_q;
        stall_cycles_d = stall_cycles_q;
        if ((state_q == IDLE) && start) begin
            frame_cycles_d = '0;
            stall_cycles_d = '0;
        end else begin
            if ((state_q != IDLE) && (frame_cycles_q != '1)) begin
                frame_cycles_d = frame_cycles_q + 32'd1;
            end
            if ((state_q == ISSUE) && (inflight_q == INFLIGHT_MAX) && (stall_cycles_q != '1)) begin
                stall_cycles_d = stall_cycles_q + 32'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            frame_cycles_q <= '0;
            stall_cycles_q <= '0;
        end else begin
            frame_cycles_q <= frame_cycles_d;
            stall_cycles_q <= stall_cycles_d;
        end
    end

    assign frame_cycles = frame_cycles_q;
    assign stall_cycles = stall_cycles_q;
`endif

endmodule

// File: tb/tb_pixel_scheduler.sv
// Scoreboard bench for pixel_scheduler: a 4x3 free-running instance (16 credits)
// and a 4x3 throttled instance (2 credits) exercised with directed sequences.
module tb_pixel_scheduler;

    typedef struct packed {
        logic [31:0] x;
        logic [31:0] y;
        logic        last;
    } px_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_a, a_start, a_abort, a_credit;
    logic [31:0] a_sx, a_sy;
    logic        a_cv, a_pl, a_busy, a_fd, a_err;
    logic [4:0]  a_inflight;

    logic        rst_b, b_start, b_abort, b_credit;
    logic [31:0] b_sx, b_sy;
    logic        b_cv, b_pl, b_busy, b_fd, b_err;
    logic [1:0]  b_inflight;

`ifdef PIXEL_SCHED_PERF_EN
    logic [31:0] a_fc, a_sc, b_fc, b_sc;
`endif

    pixel_scheduler #(.SCREEN_WIDTH(4), .SCREEN_HEIGHT(3), .MAX_INFLIGHT(16)) u_dut_a (
        .clk           (clk),
        .rst           (rst_a),
        .start         (a_start),
        .abort         (a_abort),
        .credit_return (a_credit),
        .screen_x      (a_sx),
        .screen_y      (a_sy),
        .coords_valid  (a_cv),
        .pixel_last    (a_pl),
        .busy          (a_busy),
        .frame_done    (a_fd),
        .inflight      (a_inflight),
        .credit_err    (a_err)
`ifdef PIXEL_SCHED_PERF_EN
        ,
        .frame_cycles  (a_fc),
        .stall_cycles  (a_sc)
`endif
    );

    pixel_scheduler #(.SCREEN_WIDTH(4), .SCREEN_HEIGHT(3), .MAX_INFLIGHT(2)) u_dut_b (
        .clk           (clk),
        .rst           (rst_b),
        .start         (b_start),
        .abort         (b_abort),
        .credit_return (b_credit),
        .screen_x      (b_sx),
        .screen_y      (b_sy),
        .coords_valid  (b_cv),
        .pixel_last    (b_pl),
        .busy          (b_busy),
        .frame_done    (b_fd),
        .inflight      (b_inflight),
        .credit_err    (b_err)
`ifdef PIXEL_SCHED_PERF_EN
        ,
        .frame_cycles  (b_fc),
        .stall_cycles  (b_sc)
`endif
    );

    int n_cmp = 0;
    int n_bad = 0;
    int fd_a = 0;
    int fd_b = 0;
    int na = 0;
    int cyc = 0;
    int a_first = -1;
    int a_last = -1;
    logic [31:0] a_x3 = '0;
    px_t qa[$];
    px_t qb[$];
    px_t ea, eb;
    logic [1:0] dly = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
        end
    endtask

    function automatic px_t mk(input logic [31:0] x, input logic [31:0] y, input logic last);
        px_t p;
        p.x = x;
        p.y = y;
        p.last = last;
        return p;
    endfunction

    task automatic chk_rst(input string tag, input logic [31:0] sx, input logic [31:0] sy,
                           input logic cv, input logic pl, input logic bz, input logic fd,
                           input logic [31:0] infl, input logic err);
        check({tag, "_screen_x"}, sx, 32'h0);
        check({tag, "_screen_y"}, sy, 32'h0);
        check({tag, "_coords_valid"}, 32'(cv), 32'h0);
        check({tag, "_pixel_last"}, 32'(pl), 32'h0);
        check({tag, "_busy"}, 32'(bz), 32'h0);
        check({tag, "_frame_done"}, 32'(fd), 32'h0);
        check({tag, "_inflight"}, infl, 32'h0);
        check({tag, "_credit_err"}, 32'(err), 32'h0);
    endtask

    task automatic a_go();
        @(posedge clk); #1; a_start = 1'b1;
        @(posedge clk); #1; a_start = 1'b0;
    endtask

    task automatic b_go();
        @(posedge clk); #1; b_start = 1'b1;
        @(posedge clk); #1; b_start = 1'b0;
    endtask

    task automatic b_cr();
        @(posedge clk); #1; b_credit = 1'b1;
        @(posedge clk); #1; b_credit = 1'b0;
    endtask

    task automatic b_ab();
        b_abort = 1'b1;
        @(posedge clk); #1; b_abort = 1'b0;
    endtask

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Credit loopback for instance A: coords_valid returns 3 edges later.
    initial forever begin
        @(posedge clk); #1;
        a_credit = dly[1];
        dly = {dly[0], (a_cv === 1'b1)};
    end

    initial forever begin
        @(negedge clk);
        if (rst_a === 1'b1) begin
            if (a_fd === 1'b1) fd_a++;
            if (a_cv === 1'b1) begin
                if (na == 0) a_first = cyc;
                a_last = cyc;
                if (na == 3) a_x3 = a_sx;
                na++;
                if (qa.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL a_unexpected_valid: actual x=%0h y=%0h required no pulse", a_sx, a_sy);
                end else begin
                    ea = qa.pop_front();
                    check("a_screen_x", a_sx, ea.x);
                    check("a_screen_y", a_sy, ea.y);
                    check("a_pixel_last", 32'(a_pl), 32'(ea.last));
                end
            end else begin
                check("a_last_without_valid", 32'(a_pl), 32'h0);
            end
        end
    end

    initial forever begin
        @(negedge clk);
        if (rst_b === 1'b1) begin
            if (b_fd === 1'b1) fd_b++;
            if (b_cv === 1'b1) begin
                if (qb.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL b_unexpected_valid: actual x=%0h y=%0h required no pulse", b_sx, b_sy);
                end else begin
                    eb = qb.pop_front();
                    check("b_screen_x", b_sx, eb.x);
                    check("b_screen_y", b_sy, eb.y);
                    check("b_pixel_last", 32'(b_pl), 32'(eb.last));
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_a = 1'b1; rst_b = 1'b1;
        a_start = 1'b0; a_abort = 1'b0; a_credit = 1'b0;
        b_start = 1'b0; b_abort = 1'b0; b_credit = 1'b0;
        #2;
        rst_a = 1'b0; rst_b = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk_rst("a_reset", a_sx, a_sy, a_cv, a_pl, a_busy, a_fd, 32'(a_inflight), a_err);
        chk_rst("b_reset", b_sx, b_sy, b_cv, b_pl, b_busy, b_fd, 32'(b_inflight), b_err);
        @(negedge clk);
        rst_a = 1'b1; rst_b = 1'b1;

        // Free run, 16 credits, 3-cycle loopback.
        qa.push_back(mk(32'h0000_0000, 32'h0000_0000, 1'b0));
        qa.push_back(mk(32'h0020_0000, 32'h0000_0000, 1'b0));
        qa.push_back(mk(32'h0040_0000, 32'h0000_0000, 1'b0));
        qa.push_back(mk(32'h0060_0000, 32'h0000_0000, 1'b0));
        qa.push_back(mk(32'h0000_0000, 32'h0020_0000, 1'b0));
        qa.push_back(mk(32'h0020_0000, 32'h0020_0000, 1'b0));
        qa.push_back(mk(32'h0040_0000, 32'h0020_0000, 1'b0));
        qa.push_back(mk(32'h0060_0000, 32'h0020_0000, 1'b0));
        qa.push_back(mk(32'h0000_0000, 32'h0040_0000, 1'b0));
        qa.push_back(mk(32'h0020_0000, 32'h0040_0000, 1'b0));
        qa.push_back(mk(32'h0040_0000, 32'h0040_0000, 1'b0));
        qa.push_back(mk(32'h0060_0000, 32'h0040_0000, 1'b1));
        a_go();
        check("a_busy_after_start", 32'(a_busy), 32'h1);
        for (int i = 0; i < 200 && fd_a == 0; i++) @(posedge clk);
        repeat (5) @(posedge clk);
        #1;
        check("a_frame_done_count", 32'(fd_a), 32'd1);
        check("a_pixels_left", 32'(qa.size()), 32'd0);
        check("a_pulse_count", 32'(na), 32'd12);
        check("a_back_to_back_span", 32'(a_last - a_first), 32'd11);
        check("a_pixel3_x", a_x3, 32'h0060_0000);
        check("a_busy_after_frame", 32'(a_busy), 32'h0);
        check("a_inflight_after_frame", 32'(a_inflight), 32'h0);
        check("a_credit_err", 32'(a_err), 32'h0);

        // Credit throttle: two pulses then blocked.
        qb.push_back(mk(32'h0000_0000, 32'h0000_0000, 1'b0));
        qb.push_back(mk(32'h0020_0000, 32'h0000_0000, 1'b0));
        b_go();
        check("b_busy_after_start", 32'(b_busy), 32'h1);
        repeat (8) @(posedge clk);
        #1;
        check("b_throttle_inflight", 32'(b_inflight), 32'd2);
        check("b_throttle_pending", 32'(qb.size()), 32'd0);
        qb.push_back(mk(32'h0040_0000, 32'h0000_0000, 1'b0));
        b_cr();
        repeat (4) @(posedge clk);
        #1;
        check("b_one_credit_inflight", 32'(b_inflight), 32'd2);
        check("b_one_credit_pending", 32'(qb.size()), 32'd0);
        qb.push_back(mk(32'h0060_0000, 32'h0000_0000, 1'b0)); b_cr(); repeat (3) @(posedge clk);
        qb.push_back(mk(32'h0000_0000, 32'h0020_0000, 1'b0)); b_cr(); repeat (3) @(posedge clk);
        qb.push_back(mk(32'h0020_0000, 32'h0020_0000, 1'b0)); b_cr(); repeat (3) @(posedge clk);
        qb.push_back(mk(32'h0040_0000, 32'h0020_0000, 1'b0)); b_cr(); repeat (3) @(posedge clk);
        #1;
        check("b_seven_pending", 32'(qb.size()), 32'd0);
        check("b_seven_inflight", 32'(b_inflight), 32'd2);

        // Reset mid-frame.
        rst_b = 1'b0;
        #1;
        chk_rst("b_midreset", b_sx, b_sy, b_cv, b_pl, b_busy, b_fd, 32'(b_inflight), b_err);
        @(negedge clk);
        rst_b = 1'b1;
        qb.push_back(mk(32'h0000_0000, 32'h0000_0000, 1'b0));
        qb.push_back(mk(32'h0020_0000, 32'h0000_0000, 1'b0));
        b_go();
        repeat (6) @(posedge clk);
        #1;
        check("b_restart_inflight", 32'(b_inflight), 32'd2);
        check("b_restart_pending", 32'(qb.size()), 32'd0);

        // Abort after the 5th pulse, then drain.
        qb.push_back(mk(32'h0040_0000, 32'h0000_0000, 1'b0)); b_cr(); repeat (3) @(posedge clk);
        qb.push_back(mk(32'h0060_0000, 32'h0000_0000, 1'b0)); b_cr(); repeat (3) @(posedge clk);
        qb.push_back(mk(32'h0000_0000, 32'h0020_0000, 1'b0)); b_cr();
        @(posedge clk);
        #1;
        b_ab();
        check("b_abort_pending", 32'(qb.size()), 32'd0);
        check("b_abort_busy", 32'(b_busy), 32'h1);
        check("b_abort_inflight", 32'(b_inflight), 32'd2);
        b_cr();
        repeat (2) @(posedge clk);
        b_cr();
        check("b_drain_inflight", 32'(b_inflight), 32'd0);
        check("b_drain_busy_hold", 32'(b_busy), 32'h1);
        @(posedge clk);
        #1;
        check("b_drain_busy_fall", 32'(b_busy), 32'h0);
        check("b_abort_no_done", 32'(b_fd), 32'h0);

        // Simultaneous issue and credit at inflight == 1.
        qb.push_back(mk(32'h0000_0000, 32'h0000_0000, 1'b0));
        qb.push_back(mk(32'h0020_0000, 32'h0000_0000, 1'b0));
        qb.push_back(mk(32'h0040_0000, 32'h0000_0000, 1'b0));
        b_go();
        @(posedge clk); #1; b_credit = 1'b1;
        @(posedge clk); #1; b_credit = 1'b0;
        check("b_simul_inflight", 32'(b_inflight), 32'd1);
        check("b_simul_no_err", 32'(b_err), 32'h0);
        @(posedge clk);
        #1;
        check("b_simul_next_inflight", 32'(b_inflight), 32'd2);
        b_ab();
        b_cr();
        b_cr();
        repeat (2) @(posedge clk);
        #1;
        check("b_simul_idle", 32'(b_busy), 32'h0);
        check("b_simul_pending", 32'(qb.size()), 32'd0);

        // Credit while idle sets sticky credit_err until the next start.
        b_cr();
        check("b_idle_credit_err", 32'(b_err), 32'h1);
        check("b_idle_credit_inflight", 32'(b_inflight), 32'd0);
        repeat (3) @(posedge clk);
        #1;
        check("b_credit_err_sticky", 32'(b_err), 32'h1);
        qb.push_back(mk(32'h0000_0000, 32'h0000_0000, 1'b0));
        qb.push_back(mk(32'h0020_0000, 32'h0000_0000, 1'b0));
        b_go();
        check("b_err_cleared_by_start", 32'(b_err), 32'h0);
        repeat (4) @(posedge clk);
        #1;
        b_ab();
        b_cr();
        b_cr();
        repeat (2) @(posedge clk);
        #1;
        check("b_err_frame_idle", 32'(b_busy), 32'h0);
        check("b_err_frame_pending", 32'(qb.size()), 32'd0);

`ifdef PIXEL_SCHED_PERF_EN
        qb.push_back(mk(32'h0000_0000, 32'h0000_0000, 1'b0));
        qb.push_back(mk(32'h0020_0000, 32'h0000_0000, 1'b0));
        b_go();
        repeat (12) @(posedge clk);
        #1;
        check("b_stall_cycles", b_sc, 32'd10);
        check("b_frame_cycles", b_fc, 32'd12);
        b_ab();
        b_cr();
        b_cr();
        repeat (2) @(posedge clk);
        #1;
        check("b_perf_pending", 32'(qb.size()), 32'd0);
`endif

        check("b_frame_done_count", 32'(fd_b), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
